ring_counter_pn: RTL
====================

# ring_counter_pn

Parametrised ring/Johnson counter built from the team's flip-flop behaviour: a WIDTH-bit circular shift register with a programmable seed, direction control, parallel load, synchronous clear/preset, wrap detection and optional illegal-state self-correction. It is the next-generation core of the ring-counter FPGA design. It replaces fixed 4-stage chains of discrete flip-flops and drives LED/strobe sequencing logic directly from q_o.

## Interface
- WIDTH, 4: number of stages; legal range 2..32.
- INIT, 1: seed pattern (WIDTH bits) loaded on rst_i/pr_i; ring-mode wrap target.
- SELF_CORRECT, 1: 1 = step from an illegal state reloads the legal default; 0 = illegal pattern keeps circulating.
- clk_i  in  1  single clock, all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clr_i  in  1  synchronous clear, q_o <= 0.
- pr_i  in  1  synchronous preset, q_o <= INIT.
- en_i  in  1  step/load enable; low = hold.
- dir_i  in  1  0 = shift toward MSB, 1 = shift toward LSB.
- mode_i  in  2  00 ring, 01 Johnson, 10 load, 11 hold.
- d_i  in  WIDTH  parallel load data.
- q_o  out  WIDTH  counter state (registered).
- wrap_o  out  1  one-cycle pulse, registered with q_o.
- err_o  out  1  sticky illegal-state flag.

## Operation
- Priority per edge: rst_i > clr_i > pr_i > en_i. With en_i low, everything holds and wrap_o is 0.
- rst_i: q_o=INIT, wrap_o=0, err_o=0. clr_i: q_o=0, wrap_o=0, err_o=0. pr_i: q_o=INIT, wrap_o=0, err_o=0.
- Ring step, dir 0: next={q[W-2:0],q[W-1]}. Ring step, dir 1: next={q[0],q[W-1:1]}.
- Johnson step, dir 0: next={q[W-2:0],~q[W-1]}. Johnson step, dir 1: next={~q[0],q[W-1:1]}.
- Load (mode 10, en_i=1): q_o<=d_i, err_o cleared, wrap_o=0. No validity check on load.
- Hold (mode 11): q_o unchanged, wrap_o=0.
- Legality, checked on the current q_o at a step cycle:
  - ring: popcount(q)==popcount(INIT).
  - Johnson: at most 2 circular adjacent-bit transitions (includes 0 and all-ones).
- Illegal at a step cycle: err_o<=1, sticky until rst/clr/pr/load.
  - SELF_CORRECT=1: next = INIT (ring) or 0 (Johnson), instead of the rotated value.
  - SELF_CORRECT=0: normal rotation.
- wrap_o<=1 when a ring step produces next==INIT, or a Johnson step produces next==0. A self-corrected step never raises wrap_o.
- Mode change between steps is allowed and takes effect on that edge. A ring→Johnson switch judges legality by Johnson rules.

## Timing
- Latency: 1 cycle; q_o, wrap_o and err_o all update on the same edge.
- Ring period is WIDTH steps for one-hot INIT. Johnson period is 2·WIDTH steps.
- Reset mid-sequence: next edge gives q_o=INIT, flags 0. No partial state survives.
- Simultaneous clr_i and pr_i: clear wins, q_o=0.
- Every input is sampled only at the edge; no asynchronous paths.

## Structure
- Package ring_counter_pkg: mode constants MODE_RING=2'b00, MODE_JOHNSON=2'b01, MODE_LOAD=2'b10, MODE_HOLD=2'b11, and a WIDTH range check.
- One sub-module, ring_code_check: combinational, parameter WIDTH. Inputs q, mode and INIT popcount; output legal. Implements the popcount and circular-transition checks.
- Top level holds the next-state mux, the q/wrap/err registers and the priority logic.

## Test plan
All scenarios use WIDTH=4 and INIT=0001.
- Reset, then ring, dir 0, 4 steps: q_o=0010,0100,1000,0001. wrap_o=1 only with 0001. err_o=0.
- From 0001, ring, dir 1, one step: q_o=1000. Drop en_i for 3 cycles: q_o holds 1000, wrap_o=0.
- clr_i, then Johnson, dir 0, 8 steps: q_o=0001,0011,0111,1111,1110,1100,1000,0000. wrap_o=1 only with 0000.
- Load 0110, then ring step:
  - SELF_CORRECT=1: q_o=0001, err_o=1, wrap_o=0.
  - SELF_CORRECT=0: q_o=1100, err_o=1.
  - pr_i then clears err_o.
- clr_i and pr_i together: q_o=0000. Assert rst_i mid-Johnson (q_o=0111): next edge q_o=0001, err_o=0, wrap_o=0.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared mode encodings, popcount helper and WIDTH legality for the ring/Johnson counter.
package ring_counter_pkg;

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_LOAD    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;
  // Wide enough to count up to MAX_WIDTH ones or transitions.
  localparam int unsigned CNT_W     = 6;

  function automatic bit width_ok(input int unsigned w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  function automatic logic [CNT_W-1:0] popcount32(input logic [MAX_WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_WIDTH); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ring_code_check.sv
// Combinational legality check of the current counter pattern for the selected stepping mode.
module ring_code_check
  import ring_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] init_ones,
  output logic             legal
);

  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] trans;

  // Ones count and circular adjacent-bit transition count.
  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones  = ones + CNT_W'(q[i]);
      trans = trans + CNT_W'(q[i] ^ q[(i + 1) % int'(WIDTH)]);
    end
  end

  always_comb begin
    legal = 1'b1;
    unique case (mode)
      MODE_RING:    legal = (ones == init_ones);
      MODE_JOHNSON: legal = (trans <= CNT_W'(2));
      default:      legal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ring_counter_pn.sv
// Parametrised ring/Johnson counter with seed, direction, parallel load, clear/preset,
// wrap pulse and optional illegal-state self-correction.
module ring_counter_pn
  import ring_counter_pkg::*;
#(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] INIT         = WIDTH'(1),
  parameter bit               SELF_CORRECT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             pr_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o,
  output logic             err_o
);

  if (!width_ok(WIDTH)) begin : g_width_err
    $error("ring_counter_pn: WIDTH must be within 2..32");
  end

  localparam logic [CNT_W-1:0] INIT_ONES = popcount32(MAX_WIDTH'(INIT));

  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q_n;
  logic             wrap_n;
  logic             err_n;
  logic             legal;

  ring_code_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .q         (q_o),
    .mode      (mode_i),
    .init_ones (INIT_ONES),
    .legal     (legal)
  );

  // Candidate rotation and the pattern that marks a completed cycle.
  always_comb begin
    step_q = q_o;
    target = '0;
    if (mode_i == MODE_RING) begin
      step_q = dir_i ? {q_o[0], q_o[WIDTH-1:1]} : {q_o[WIDTH-2:0], q_o[WIDTH-1]};
      target = INIT;
    end else begin
      step_q = dir_i ? {~q_o[0], q_o[WIDTH-1:1]} : {q_o[WIDTH-2:0], ~q_o[WIDTH-1]};
    end
  end

  // Next-state selection: clear > preset > enabled step/load/hold.
  always_comb begin
    q_n    = q_o;
    wrap_n = 1'b0;
    err_n  = err_o;
    if (clr_i) begin
      q_n   = '0;
      err_n = 1'b0;
    end else if (pr_i) begin
      q_n   = INIT;
      err_n = 1'b0;
    end else if (en_i) begin
      unique case (mode_i)
        MODE_RING, MODE_JOHNSON: begin
          if (!legal) begin
            err_n = 1'b1;
          end
          if (!legal && SELF_CORRECT) begin
            q_n = target;
          end else begin
            q_n    = step_q;
            wrap_n = (step_q == target);
          end
        end
        MODE_LOAD: begin
          q_n   = d_i;
          err_n = 1'b0;
        end
        default: begin
          q_n = q_o;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o    <= INIT;
      wrap_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      q_o    <= q_n;
      wrap_o <= wrap_n;
      err_o  <= err_n;
    end
  end

endmodule
